mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single system bus (instruction/data memory, timer, TBMAN) between the CPU instruction-fetch port and data (load/store) port. Arbitrates simultaneous requests, decodes the target region and rejects unmapped addresses, holds the winning transaction on the bus until the slave acknowledges, and returns read data or an error to the originating port. A per-transaction timeout prevents a silent slave from hanging the pipeline.

## Interface
- TIMEOUT, 15: max cycles in BUS state waiting for bus_ready before error response (1..255)
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request captured
- i_rvalid  out  1  one-cycle pulse: fetch response valid
- i_rdata  out  32  fetch read data, valid with i_rvalid
- i_err  out  1  error flag, valid with i_rvalid
- d_req  in  1  data request; held with d_addr/d_we/d_be/d_wdata until d_gnt
- d_addr  in  32  data address
- d_we  in  1  1 = write
- d_be  in  4  byte enables
- d_wdata  in  32  write data
- d_gnt, d_rvalid, d_rdata[31:0], d_err  out  data-port equivalents of i_*
- bus_valid  out  1  transaction active on bus
- bus_addr  out  32  captured address
- bus_we  out  1  captured write flag (0 for fetch)
- bus_be  out  4  captured byte enables (4'hF for fetch)
- bus_wdata  out  32  captured write data (0 for fetch)
- bus_ready  in  1  slave acknowledge; bus_rdata valid same cycle
- bus_rdata  in  32  slave read data

## Operation
- States: IDLE, BUS, ERR.
- Address map: mapped iff addr[31:28] is 4'h1 or 4'h3 (memory), addr[31:12] == 20'h80001 (timer), addr[31:12] == 20'h8000F (TBMAN).
- IDLE: if any req, choose winner (see Configuration), capture its addr/we/be/wdata and owner. Mapped -> BUS; unmapped -> ERR. Winner's gnt pulses in the next cycle. No req -> stay.
- BUS: bus_valid=1, bus_* = captured values, timeout counter increments each cycle from 0. bus_ready=1 -> capture bus_rdata, IDLE, owner's rvalid=1, err=0 next cycle. Counter reaches TIMEOUT-1 without bus_ready -> IDLE, owner's rvalid=1, err=1, rdata=0 next cycle.
- ERR: no bus activity; -> IDLE, owner's rvalid=1, err=1, rdata=0 next cycle.
- Loser's req is not acknowledged; it must remain asserted and is arbitrated again in the next IDLE.
- Write responses: rvalid still pulses; rdata is whatever bus_rdata held at bus_ready (don't care).
- Only one transaction outstanding; exactly one rvalid per gnt.

## Timing
- Reset values: all gnt/rvalid/err = 0, rdata = 0, bus_valid = 0, bus_addr/bus_wdata = 0, bus_we = 0, bus_be = 0, state IDLE, counter 0, RR pointer favours data port.
- Request sampled in IDLE at cycle N -> gnt and bus_valid at N+1.
- bus_ready at cycle M (in BUS) -> rvalid at M+1; state IDLE at M+1, so next request may be sampled at M+1 (min 2 cycles per transaction).
- Unmapped: req at N -> gnt at N+1 (ERR) -> rvalid/err at N+2.
- Timeout: bus_valid high for exactly TIMEOUT cycles, rvalid/err one cycle after last.
- bus_ready while not in BUS: ignored.
- reset mid-transaction: in-flight transaction dropped, no rvalid issued, all outputs to reset values next cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous i_req/d_req, winner is the port not granted most recently; pointer updates on every gnt.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data port always wins simultaneous requests; fetch served only when d_req=0.

## Test plan
- Single fetch i_addr=32'h1000_0000, bus_ready one cycle after bus_valid, bus_rdata=32'hDEADBEEF -> i_gnt at N+1, i_rvalid at N+3, i_rdata=32'hDEADBEEF, i_err=0.
- Data write d_addr=32'h8000_1004, d_we=1, d_be=4'h3, d_wdata=32'h0000_1234 -> bus_we=1, bus_be=4'h3, bus_wdata matches; d_rvalid, d_err=0.
- Unmapped d_addr=32'h2000_0000 -> bus_valid never asserted, d_gnt at N+1, d_rvalid/d_err=1, d_rdata=0 at N+2.
- bus_ready held low, TIMEOUT=15, i_addr=32'h8000_F000 -> bus_valid high 15 cycles, then i_rvalid=1, i_err=1.
- i_req and d_req held continuously, both mapped, bus_ready immediate -> with ARB_ROUND_ROBIN_EN grants alternate D,I,D,I; without, only d_gnt until d_req drops.
- reset asserted in BUS state -> next cycle bus_valid=0, no rvalid, state IDLE; fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Shares the system bus between the CPU fetch and data ports, with
//            address decode, per-transaction timeout and error responses.
//            Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise
//            the data port has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_ERR  = 2'd2;
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_owner_d;
    logic        r_i_gnt, r_d_gnt, r_i_rvalid, r_d_rvalid, r_i_err, r_d_err;
    logic [31:0] r_i_rdata, r_d_rdata;
    logic        r_bus_valid, r_bus_we;
    logic [31:0] r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_be;

    logic        w_any, w_pick_d, w_mapped;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_owner_d_nxt, w_i_gnt_nxt, w_d_gnt_nxt, w_bus_valid_nxt;
    logic        w_rsp_nxt, w_err_nxt, w_we_nxt;
    logic [31:0] w_rdata_nxt, w_addr_nxt, w_wdata_nxt;
    logic [3:0]  w_be_nxt;

    assign w_any = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;     // port granted most recently; reset value lets data win first

    assign w_pick_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == c_ST_IDLE && w_any) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = d_req;
`endif

    assign w_sel_addr = w_pick_d ? d_addr : i_addr;
    assign w_mapped   = (w_sel_addr[31:28] == 4'h1) || (w_sel_addr[31:28] == 4'h3) ||
                        (w_sel_addr[31:12] == 20'h80001) || (w_sel_addr[31:12] == 20'h8000F);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_owner_d_nxt   = r_owner_d;
        w_addr_nxt      = r_bus_addr;
        w_we_nxt        = r_bus_we;
        w_be_nxt        = r_bus_be;
        w_wdata_nxt     = r_bus_wdata;
        w_bus_valid_nxt = 1'b0;
        w_i_gnt_nxt     = 1'b0;
        w_d_gnt_nxt     = 1'b0;
        w_rsp_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    w_owner_d_nxt = w_pick_d;
                    w_i_gnt_nxt   = ~w_pick_d;
                    w_d_gnt_nxt   = w_pick_d;
                    w_cnt_nxt     = '0;
                    w_addr_nxt    = w_sel_addr;
                    w_we_nxt      = w_pick_d ? d_we : 1'b0;
                    w_be_nxt      = w_pick_d ? d_be : 4'hF;
                    w_wdata_nxt   = w_pick_d ? d_wdata : 32'h0;
                    if (w_mapped) begin
                        w_state_nxt     = c_ST_BUS;
                        w_bus_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_ERR;
                    end
                end
            end
            c_ST_BUS: begin
                if (bus_ready) begin
                    w_state_nxt = c_ST_IDLE;
                    w_rsp_nxt   = 1'b1;
                    w_rdata_nxt = bus_rdata;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_rsp_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt       = r_cnt + 8'd1;
                    w_bus_valid_nxt = 1'b1;
                end
            end
            c_ST_ERR: begin
                w_state_nxt = c_ST_IDLE;
                w_rsp_nxt   = 1'b1;
                w_err_nxt   = 1'b1;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_owner_d   <= 1'b0;
            r_i_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_i_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner_d   <= w_owner_d_nxt;
            r_i_gnt     <= w_i_gnt_nxt;
            r_d_gnt     <= w_d_gnt_nxt;
            // Responses always go to the port that owns the in-flight transaction
            r_i_rvalid  <= w_rsp_nxt & ~r_owner_d;
            r_d_rvalid  <= w_rsp_nxt & r_owner_d;
            r_i_err     <= w_err_nxt & ~r_owner_d;
            r_d_err     <= w_err_nxt & r_owner_d;
            if (w_rsp_nxt && !r_owner_d) r_i_rdata <= w_rdata_nxt;
            if (w_rsp_nxt && r_owner_d)  r_d_rdata <= w_rdata_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_bus_addr  <= w_addr_nxt;
            r_bus_we    <= w_we_nxt;
            r_bus_be    <= w_be_nxt;
            r_bus_wdata <= w_wdata_nxt;
        end
    end

    assign i_gnt     = r_i_gnt;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign bus_valid = r_bus_valid;
    assign bus_addr  = r_bus_addr;
    assign bus_we    = r_bus_we;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Self-checking bench for mem_bus_arbiter; directed scenarios plus
//            randomized transactions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, bus_ready;
    logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic        bus_valid, bus_we;
    logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int n_pass  = 0;
    int n_total = 0;

    // Everything observable about one transaction, in cycles after the request edge
    typedef struct packed {
        int          gnt_cyc;
        int          rv_cyc;
        int          bv;
        int          other;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic is_mapped(input logic [31:0] a);
        return (a[31:28] == 4'h1) || (a[31:28] == 4'h3) ||
               (a[31:12] == 20'h80001) || (a[31:12] == 20'h8000F);
    endfunction

    // Expected outcome of a lone request whose slave answers 'delay' cycles after bus_valid
    function automatic txn_t model(input logic is_d, input logic [31:0] a, input logic we,
                                   input logic [3:0] be, input logic [31:0] wd,
                                   input int delay, input logic [31:0] rd);
        txn_t m;
        m = '0;
        m.gnt_cyc = 1;
        if (!is_mapped(a)) begin
            m.rv_cyc = 2;
            m.err    = 1'b1;
        end else begin
            m.addr  = a;
            m.we    = is_d ? we : 1'b0;
            m.be    = is_d ? be : 4'hF;
            m.wdata = is_d ? wd : 32'h0;
            if (delay < TIMEOUT) begin
                m.bv     = delay + 1;
                m.rv_cyc = delay + 2;
                m.rdata  = rd;
            end else begin
                m.bv     = TIMEOUT;
                m.rv_cyc = TIMEOUT + 1;
                m.err    = 1'b1;
            end
        end
        return m;
    endfunction

    // Drives one request and records what the DUT does; makes no judgement
    task automatic run_txn(input logic is_d, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int delay, input logic [31:0] rd, output txn_t o);
        o = '0;
        o.gnt_cyc = -1;
        o.rv_cyc  = -1;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_addr = a; d_we = we; d_be = be; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        for (int c = 1; c <= TIMEOUT + 8; c++) begin
            @(negedge clk);
            if (is_d ? d_gnt : i_gnt) begin
                o.gnt_cyc = c;
                i_req = 1'b0;
                d_req = 1'b0;
            end
            if (is_d ? (i_gnt | i_rvalid) : (d_gnt | d_rvalid)) o.other = o.other + 1;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (bus_valid) begin
                o.bv    = o.bv + 1;
                o.addr  = bus_addr;
                o.we    = bus_we;
                o.be    = bus_be;
                o.wdata = bus_wdata;
                if (o.bv == delay + 1) begin
                    bus_ready = 1'b1;
                    bus_rdata = rd;
                end
            end
            if (is_d ? d_rvalid : i_rvalid) begin
                o.rv_cyc = c;
                o.err    = is_d ? d_err : i_err;
                o.rdata  = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        bus_ready = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err});
        else n_pass++;
        n_total++;
        if ({i_rdata, d_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h %h want 0 0", i_rdata, d_rdata);
        else n_pass++;
        n_total++;
        if ({bus_valid, bus_addr, bus_we, bus_be, bus_wdata} !== 70'h0)
            $display("FAIL reset_bus: got valid=%b addr=%h we=%b be=%h wdata=%h want all 0",
                     bus_valid, bus_addr, bus_we, bus_be, bus_wdata);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        txn_t o, e;
        e = model(1'b0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 1, 32'hDEADBEEF);
        run_txn(1'b0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 1, 32'hDEADBEEF, o);
        n_total++;
        if (o.gnt_cyc !== 1 || o.rv_cyc !== 3)
            $display("FAIL fetch_timing: got gnt@%0d rvalid@%0d want gnt@1 rvalid@3", o.gnt_cyc, o.rv_cyc);
        else n_pass++;
        n_total++;
        if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0)
            $display("FAIL fetch_data: got rdata=%h err=%b want DEADBEEF err=0", o.rdata, o.err);
        else n_pass++;
        n_total++;
        if (o.we !== 1'b0 || o.be !== 4'hF || o.wdata !== 32'h0 || o.addr !== 32'h1000_0000)
            $display("FAIL fetch_bus: got addr=%h we=%b be=%h wdata=%h want 10000000 0 f 0",
                     o.addr, o.we, o.be, o.wdata);
        else n_pass++;
        n_total++;
        if (o !== e)
            $display("FAIL fetch_model: got bv=%0d other=%0d want bv=%0d other=%0d", o.bv, o.other, e.bv, e.other);
        else n_pass++;
    endtask

    task automatic test_write();
        txn_t o;
        run_txn(1'b1, 32'h8000_1004, 1'b1, 4'h3, 32'h0000_1234, 0, 32'h5555_AAAA, o);
        n_total++;
        if (o.we !== 1'b1 || o.be !== 4'h3 || o.wdata !== 32'h0000_1234 || o.addr !== 32'h8000_1004)
            $display("FAIL write_bus: got addr=%h we=%b be=%h wdata=%h want 80001004 1 3 00001234",
                     o.addr, o.we, o.be, o.wdata);
        else n_pass++;
        n_total++;
        if (o.gnt_cyc !== 1 || o.rv_cyc !== 2 || o.err !== 1'b0 || o.other !== 0)
            $display("FAIL write_rsp: got gnt@%0d rvalid@%0d err=%b other=%0d want 1 2 0 0",
                     o.gnt_cyc, o.rv_cyc, o.err, o.other);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        txn_t o;
        run_txn(1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h1111_2222, o);
        n_total++;
        if (o.bv !== 0)
            $display("FAIL unmapped_bus: got bus_valid cycles=%0d want 0", o.bv);
        else n_pass++;
        n_total++;
        if (o.gnt_cyc !== 1 || o.rv_cyc !== 2)
            $display("FAIL unmapped_timing: got gnt@%0d rvalid@%0d want 1 2", o.gnt_cyc, o.rv_cyc);
        else n_pass++;
        n_total++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0)
            $display("FAIL unmapped_rsp: got err=%b rdata=%h want 1 0", o.err, o.rdata);
        else n_pass++;
    endtask

    task automatic test_timeout();
        txn_t o;
        run_txn(1'b0, 32'h8000_F000, 1'b0, 4'hF, 32'h0, 1000, 32'h0, o);
        n_total++;
        if (o.bv !== 15 || o.rv_cyc !== 16)
            $display("FAIL timeout_len: got bus_valid cycles=%0d rvalid@%0d want 15 16", o.bv, o.rv_cyc);
        else n_pass++;
        n_total++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0)
            $display("FAIL timeout_rsp: got err=%b rdata=%h want 1 0", o.err, o.rdata);
        else n_pass++;
        // Slave answering in the final allowed cycle still succeeds
        run_txn(1'b1, 32'h8000_1000, 1'b0, 4'hF, 32'h0, TIMEOUT - 1, 32'hCAFE_0001, o);
        n_total++;
        if (o.err !== 1'b0 || o.rdata !== 32'hCAFE_0001 || o.bv !== TIMEOUT)
            $display("FAIL timeout_edge: got err=%b rdata=%h bv=%0d want 0 cafe0001 %0d",
                     o.err, o.rdata, o.bv, TIMEOUT);
        else n_pass++;
    endtask

    task automatic test_stray_ready();
        int seen = 0;
        @(negedge clk);
        bus_ready = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(i_rvalid) + int'(d_rvalid) + int'(bus_valid) + int'(i_gnt) + int'(d_gnt);
        end
        bus_ready = 1'b0;
        n_total++;
        if (seen !== 0)
            $display("FAIL stray_ready: got %0d output events want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic m_last_d = 1'b0;
        logic lvl_d = 1'b1;
        logic exp_d;
        int   ng = 0;
        int   nrv = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        i_addr = 32'h1000_0040;
        d_addr = 32'h3000_0080; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(negedge clk);
            bus_ready = bus_valid;
            bus_rdata = $urandom;
            nrv += int'(i_rvalid) + int'(d_rvalid);
            if (i_gnt || d_gnt) begin
                if (!lvl_d) exp_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                else exp_d = ~m_last_d;
`else
                else exp_d = 1'b1;
`endif
                m_last_d = exp_d;
                n_total++;
                if ({i_gnt, d_gnt} !== (exp_d ? 2'b01 : 2'b10))
                    $display("FAIL arb_grant[%0d]: got i_gnt,d_gnt=%b want %b",
                             ng, {i_gnt, d_gnt}, exp_d ? 2'b01 : 2'b10);
                else n_pass++;
                ng++;
                if (ng == 4) begin
                    d_req = 1'b0;
                    lvl_d = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bus_ready = bus_valid;
            nrv += int'(i_rvalid) + int'(d_rvalid);
        end
        bus_ready = 1'b0;
        n_total++;
        if (ng !== 6 || nrv !== 6)
            $display("FAIL arb_count: got grants=%0d rvalids=%0d want 6 6", ng, nrv);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        txn_t o, e;
        int   stray = 0;
        int   got_gnt = 0;
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 32'h3000_1000;
        for (int c = 0; c < 5 && got_gnt == 0; c++) begin
            @(negedge clk);
            if (i_gnt) got_gnt = 1;
        end
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (got_gnt !== 1 || bus_valid !== 1'b1)
            $display("FAIL rstmid_setup: got gnt=%0d bus_valid=%b want 1 1", got_gnt, bus_valid);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus_valid, i_rvalid, d_rvalid, i_gnt, d_gnt} !== 5'b0 || bus_addr !== 32'h0)
            $display("FAIL rstmid_clear: got valid/rv/gnt=%b addr=%h want 00000 0",
                     {bus_valid, i_rvalid, d_rvalid, i_gnt, d_gnt}, bus_addr);
        else n_pass++;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            stray += int'(i_rvalid) + int'(d_rvalid) + int'(bus_valid);
        end
        n_total++;
        if (stray !== 0)
            $display("FAIL rstmid_quiet: got %0d events want 0", stray);
        else n_pass++;
        e = model(1'b0, 32'h1000_0100, 1'b0, 4'hF, 32'h0, 2, 32'h0BAD_F00D);
        run_txn(1'b0, 32'h1000_0100, 1'b0, 4'hF, 32'h0, 2, 32'h0BAD_F00D, o);
        n_total++;
        if (o !== e)
            $display("FAIL rstmid_fresh: got rv@%0d err=%b rdata=%h want rv@%0d err=%b rdata=%h",
                     o.rv_cyc, o.err, o.rdata, e.rv_cyc, e.err, e.rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        txn_t        o, e;
        logic [31:0] r, a, wd, rd;
        logic        is_d, we;
        logic [3:0]  be;
        int          dly;
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0: a = {4'h1, r[27:0]};
                1: a = {4'h3, r[27:0]};
                2: a = {20'h80001, r[11:0]};
                3: a = {20'h8000F, r[11:0]};
                4: a = {4'h2, r[27:0]};
                5: a = {20'h80002, r[11:0]};
                6: a = {4'h0, r[27:0]};
                default: a = {20'h8000E, r[11:0]};
            endcase
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            be   = is_d ? 4'($urandom_range(1, 15)) : 4'hF;
            wd   = is_d ? $urandom : 32'h0;
            dly  = $urandom_range(0, TIMEOUT + 1);
            rd   = $urandom;
            e = model(is_d, a, we, be, wd, dly, rd);
            run_txn(is_d, a, we, be, wd, dly, rd, o);
            // Read data returned for a successful write carries no meaning
            if (is_d && we && !e.err) begin
                e.rdata = '0;
                o.rdata = '0;
            end
            n_total++;
            if (o !== e)
                $display("FAIL rand[%0d] port=%s addr=%h dly=%0d: got gnt@%0d rv@%0d bv=%0d err=%b rdata=%h we=%b be=%h wd=%h other=%0d want gnt@%0d rv@%0d bv=%0d err=%b rdata=%h we=%b be=%h wd=%h",
                         n, is_d ? "D" : "I", a, dly, o.gnt_cyc, o.rv_cyc, o.bv, o.err, o.rdata,
                         o.we, o.be, o.wdata, o.other, e.gnt_cyc, e.rv_cyc, e.bv, e.err, e.rdata,
                         e.we, e.be, e.wdata);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0;
        test_reset();
        test_fetch();
        test_write();
        test_unmapped();
        test_timeout();
        test_stray_ready();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
